// File: rtl/sdram_ref_arbiter.sv
// sdram_ref_arbiter: shares the SDRAM command slot between host reads/writes and auto-refresh.
// Define SDRAM_REF_PULLIN_EN to issue early refreshes from idle once half an interval has elapsed.
module sdram_ref_arbiter #(
    parameter int REF_INTERVAL = 780,
    parameter int MAX_POSTPONE = 4
) (
    input  logic                                 hclk,
    input  logic                                 nrst,
    input  logic                                 init_done,
    input  logic                                 host_req,
    input  logic                                 host_we,
    output logic                                 host_grant,
    output logic                                 mc_cmd_valid,
    output logic [1:0]                           mc_cmd_type,
    input  logic                                 mc_ready,
    input  logic                                 mc_done,
    output logic [$clog2(MAX_POSTPONE+1)-1:0]    ref_pending,
    output logic                                 ref_overflow,
    output logic                                 busy_n
);
    localparam int CW = $clog2(REF_INTERVAL);
    localparam int PW = $clog2(MAX_POSTPONE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_POSTPONE);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    typedef enum logic [2:0] {IDLE, HOST_ISSUE, HOST_WAIT, REF_ISSUE, REF_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          we_q, we_d;
    logic          valid_q, valid_d;
    logic [1:0]    type_q, type_d;
    logic          grant_q, grant_d;
    logic          busy_n_q, busy_n_d;
    logic          accept, ref_accept, owed_accept, pullin_accept, tick;
`ifdef SDRAM_REF_PULLIN_EN
    localparam logic [CW-1:0] CNT_HALF = CW'(REF_INTERVAL / 2);
    logic          pullin_q, pullin_d;
`endif

    // A pulled-in refresh restarts the interval, so it must not also count as a tick.
    always_comb begin
        accept     = valid_q && mc_ready;
        ref_accept = accept && (state_q == REF_ISSUE);
`ifdef SDRAM_REF_PULLIN_EN
        pullin_accept = ref_accept && pullin_q;
`else
        pullin_accept = 1'b0;
`endif
        owed_accept = ref_accept && !pullin_accept;
        tick        = init_done && (cnt_q == CNT_LAST) && !pullin_accept;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pullin_accept) begin
            cnt_d = '0;
        end else if (init_done) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        pend_d = pend_q;
        ovf_d  = ovf_q || (tick && (pend_q == PEND_MAX));
        if (tick && !owed_accept && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + PW'(1);
        end else if (owed_accept && !tick) begin
            pend_d = pend_q - PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
`ifdef SDRAM_REF_PULLIN_EN
        pullin_d = pullin_q;
`endif
        case (state_q)
            IDLE: begin
                if (init_done) begin
                    if (pend_q == PEND_MAX) begin
                        state_d = REF_ISSUE;
`ifdef SDRAM_REF_PULLIN_EN
                        pullin_d = 1'b0;
`endif
                    end else if (host_req) begin
                        state_d = HOST_ISSUE;
                        we_d    = host_we;
                    end else if (pend_q != '0) begin
                        state_d = REF_ISSUE;
`ifdef SDRAM_REF_PULLIN_EN
                        pullin_d = 1'b0;
                    end else if (cnt_q >= CNT_HALF) begin
                        state_d  = REF_ISSUE;
                        pullin_d = 1'b1;
`endif
                    end
                end
            end
            HOST_ISSUE: if (accept) state_d = HOST_WAIT;
            REF_ISSUE:  if (accept) state_d = REF_WAIT;
            HOST_WAIT,
            REF_WAIT:   if (mc_done) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        valid_d = (state_d == HOST_ISSUE) || (state_d == REF_ISSUE);
        case (state_d)
            HOST_ISSUE: type_d = we_d ? CMD_WRITE : CMD_READ;
            REF_ISSUE:  type_d = CMD_REF;
            default:    type_d = CMD_NONE;
        endcase
        grant_d  = accept && (state_q == HOST_ISSUE);
        busy_n_d = (state_d == IDLE);
    end

    always_ff @(posedge hclk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= CMD_NONE;
            grant_q  <= 1'b0;
            busy_n_q <= 1'b1;
`ifdef SDRAM_REF_PULLIN_EN
            pullin_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            grant_q  <= grant_d;
            busy_n_q <= busy_n_d;
`ifdef SDRAM_REF_PULLIN_EN
            pullin_q <= pullin_d;
`endif
        end
    end

    assign host_grant   = grant_q;
    assign mc_cmd_valid = valid_q;
    assign mc_cmd_type  = type_q;
    assign ref_pending  = pend_q;
    assign ref_overflow = ovf_q;
    assign busy_n       = busy_n_q;

endmodule

// File: tb/tb_sdram_ref_arbiter.sv
// Testbench for sdram_ref_arbiter: directed scenarios plus randomized traffic against a
// behavioural slot/refresh model. Define SDRAM_REF_PULLIN_EN to check the pull-in variant.
module tb_sdram_ref_arbiter;
    localparam int RI = 16;
    localparam int MP = 4;
    localparam int PW = $clog2(MP + 1);
    localparam int VW = 1 + 2 + 1 + 1 + PW + 1;
`ifdef SDRAM_REF_PULLIN_EN
    localparam bit PULLIN = 1'b1;
`else
    localparam bit PULLIN = 1'b0;
`endif
    localparam logic [VW-1:0] RESET_VEC = {1'b0, 2'b00, 1'b0, 1'b1, {PW{1'b0}}, 1'b0};

    logic hclk = 1'b0;
    logic nrst = 1'b1;
    logic init_done = 1'b0, host_req = 1'b0, host_we = 1'b0, mc_ready = 1'b0;
    logic mc_done;
    logic host_grant, mc_cmd_valid, ref_overflow, busy_n;
    logic [1:0] mc_cmd_type;
    logic [PW-1:0] ref_pending;
    logic [VW-1:0] dut_vec;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit spurious = 1'b0;

    // Behavioural model: interval position, owed refreshes, and what the slot holds.
    int m_cnt = 0, m_pend = 0, m_offer = 0, m_newp = 0, m_old_cnt = 0, m_old_pend = 0;
    bit m_ovf = 0, m_inflight = 0, m_grant = 0, m_pull = 0;
    bit m_acc, m_racc, m_pacc, m_tick;

    sdram_ref_arbiter #(.REF_INTERVAL(RI), .MAX_POSTPONE(MP)) dut (
        .hclk(hclk), .nrst(nrst), .init_done(init_done),
        .host_req(host_req), .host_we(host_we), .host_grant(host_grant),
        .mc_cmd_valid(mc_cmd_valid), .mc_cmd_type(mc_cmd_type),
        .mc_ready(mc_ready), .mc_done(mc_done),
        .ref_pending(ref_pending), .ref_overflow(ref_overflow), .busy_n(busy_n)
    );

    always #5 hclk = ~hclk;

    assign dut_vec = {mc_cmd_valid, mc_cmd_type, host_grant, busy_n, ref_pending, ref_overflow};

    // Controller stand-in: completion pulse 3 cycles after each accept, optional stray pulses.
    always @(posedge hclk or negedge nrst) begin
        if (!nrst) done_cnt = 0;
        else if (mc_cmd_valid && mc_ready) done_cnt = 3;
        else if (done_cnt > 0) done_cnt = done_cnt - 1;
    end
    always @(negedge hclk) mc_done = (done_cnt == 1) || (spurious && ($urandom_range(0, 7) == 0));

    always @(posedge hclk or negedge nrst) begin
        if (!nrst) begin
            m_cnt = 0; m_pend = 0; m_ovf = 0; m_offer = 0; m_inflight = 0; m_grant = 0; m_pull = 0;
        end else begin
            m_acc  = (m_offer != 0) && mc_ready;
            m_racc = m_acc && (m_offer == 3);
            m_pacc = m_racc && m_pull;
            m_tick = init_done && (m_cnt == RI - 1) && !m_pacc;
            if (m_tick && m_pend == MP) m_ovf = 1;
            m_newp = m_pend + (m_tick ? 1 : 0) - ((m_racc && !m_pacc) ? 1 : 0);
            if (m_newp > MP) m_newp = MP;
            m_old_cnt = m_cnt;
            m_old_pend = m_pend;
            if (m_pacc) m_cnt = 0;
            else if (init_done) m_cnt = (m_cnt + 1) % RI;
            m_pend  = m_newp;
            m_grant = m_acc && (m_offer != 3);
            if (m_offer != 0) begin
                if (m_acc) begin m_offer = 0; m_inflight = 1; end
            end else if (m_inflight) begin
                if (mc_done) m_inflight = 0;
            end else if (init_done) begin
                if (m_old_pend == MP) begin m_offer = 3; m_pull = 0; end
                else if (host_req) m_offer = host_we ? 2 : 1;
                else if (m_old_pend > 0) begin m_offer = 3; m_pull = 0; end
                else if (PULLIN && m_old_cnt >= RI / 2) begin m_offer = 3; m_pull = 1; end
            end
        end
    end

    function automatic logic [VW-1:0] model_vec();
        logic [1:0] t;
        t = 2'(m_offer);
        return {m_offer != 0, t, m_grant, (m_offer == 0) && !m_inflight, PW'(m_pend), m_ovf};
    endfunction

    task automatic cyc();
        @(negedge hclk);
    endtask

    task automatic drain_idle();
        bit ok;
        ok = 1'b0;
        host_req = 1'b0;
        mc_ready = 1'b1;
        for (int i = 0; i < 120 && !ok; i++) begin
            cyc();
            ok = (busy_n === 1'b1) && (ref_pending === '0) && (m_offer == 0) && !m_inflight && (m_pend == 0);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL drain_idle: busy_n=%b ref_pending=%0d, required idle with nothing owed", busy_n, ref_pending);
        end
    endtask

    task automatic test_reset();
        init_done = 1'b0; host_req = 1'b0; host_we = 1'b0; mc_ready = 1'b0; spurious = 1'b0;
        #1 nrst = 1'b0;
        repeat (3) cyc();
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++; $display("[TB] FAIL reset_values: got %b want %b", dut_vec, RESET_VEC);
        end
        init_done = 1'b1;
        repeat (2) cyc();
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++; $display("[TB] FAIL reset_hold: got %b want %b", dut_vec, RESET_VEC);
        end
        nrst = 1'b1;
    endtask

    task automatic test_refresh_tick();
        int exp_p;
        repeat (RI) cyc();
        tests++;
        if (ref_pending !== PW'(1)) begin
            fails++; $display("[TB] FAIL tick_pending: got %0d want 1", ref_pending);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("[TB] FAIL tick_model: got %b want %b", dut_vec, model_vec());
        end
        cyc();
        tests++;
        if (mc_cmd_valid !== 1'b1 || mc_cmd_type !== 2'b11) begin
            fails++; $display("[TB] FAIL refresh_offer: valid=%b type=%b want 1/11", mc_cmd_valid, mc_cmd_type);
        end
        mc_ready = 1'b1;
        cyc();
        mc_ready = 1'b0;
        exp_p = PULLIN ? 1 : 0;
        tests++;
        if (ref_pending !== PW'(exp_p) || mc_cmd_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL refresh_accept: pending=%0d valid=%b want %0d/0", ref_pending, mc_cmd_valid, exp_p);
        end
    endtask

    task automatic test_host_write();
        drain_idle();
        host_req = 1'b1; host_we = 1'b1; mc_ready = 1'b1;
        cyc();
        tests++;
        if ({mc_cmd_valid, mc_cmd_type, busy_n, host_grant} !== 5'b11000) begin
            fails++; $display("[TB] FAIL host_offer: got %b want 11000", {mc_cmd_valid, mc_cmd_type, busy_n, host_grant});
        end
        cyc();
        tests++;
        if ({host_grant, mc_cmd_valid, busy_n} !== 3'b100) begin
            fails++; $display("[TB] FAIL host_grant: got %b want 100", {host_grant, mc_cmd_valid, busy_n});
        end
        host_req = 1'b0;
        cyc();
        tests++;
        if ({host_grant, busy_n} !== 2'b00) begin
            fails++; $display("[TB] FAIL grant_pulse: got %b want 00", {host_grant, busy_n});
        end
        cyc();
        tests++;
        if (busy_n !== 1'b0) begin
            fails++; $display("[TB] FAIL busy_in_flight: got %b want 0", busy_n);
        end
        cyc();
        tests++;
        if (busy_n !== 1'b1) begin
            fails++; $display("[TB] FAIL busy_after_done: got %b want 1", busy_n);
        end
        mc_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        logic [1:0] first, second;
        n = 0; first = 2'b00; second = 2'b00;
        drain_idle();
        host_req = 1'b1; host_we = 1'b0; mc_ready = 1'b0;
        repeat (100) cyc();
        tests++;
        if (ref_pending !== PW'(MP) || ref_overflow !== 1'b1 || mc_cmd_type !== 2'b01) begin
            fails++; $display("[TB] FAIL saturate: pending=%0d ovf=%b type=%b want %0d/1/01", ref_pending, ref_overflow, mc_cmd_type, MP);
        end
        mc_ready = 1'b1;
        for (int i = 0; i < 60 && n < 2; i++) begin
            if (mc_cmd_valid === 1'b1) begin
                if (n == 0) first = mc_cmd_type;
                else second = mc_cmd_type;
                n++;
            end
            cyc();
        end
        host_req = 1'b0;
        tests++;
        if (n != 2 || first !== 2'b01 || second !== 2'b11) begin
            fails++; $display("[TB] FAIL urgent_order: n=%0d first=%b second=%b want 2/01/11", n, first, second);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("[TB] FAIL saturate_model: got %b want %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_tick_accept();
        bit hit;
        hit = 1'b0;
        drain_idle();
        host_req = 1'b0; mc_ready = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            cyc();
            hit = (m_pend == 2) && (m_cnt == RI - 1) && (mc_cmd_valid === 1'b1) && (mc_cmd_type === 2'b11);
        end
        tests++;
        if (!hit) begin
            fails++; $display("[TB] FAIL tick_accept_setup: pending=%0d valid=%b, required 2 owed with refresh offered", ref_pending, mc_cmd_valid);
        end
        mc_ready = 1'b1;
        cyc();
        mc_ready = 1'b0;
        tests++;
        if (ref_pending !== PW'(2) || mc_cmd_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL tick_accept_net: pending=%0d valid=%b want 2/0", ref_pending, mc_cmd_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        got = 1'b0;
        host_req = 1'b1; host_we = 1'b1; mc_ready = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            cyc();
            got = (host_grant === 1'b1);
        end
        host_req = 1'b0; mc_ready = 1'b0;
        tests++;
        if (!got) begin
            fails++; $display("[TB] FAIL mid_grant: host_grant=%b want 1 within bound", host_grant);
        end
        #2 nrst = 1'b0;
        #1;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++; $display("[TB] FAIL async_reset: got %b want %b", dut_vec, RESET_VEC);
        end
        cyc();
        nrst = 1'b1;
        repeat (RI - 1) cyc();
        tests++;
        if (ref_pending !== '0) begin
            fails++; $display("[TB] FAIL restart_pre_tick: pending=%0d want 0", ref_pending);
        end
        cyc();
        tests++;
        if (ref_pending !== PW'(1)) begin
            fails++; $display("[TB] FAIL restart_tick: pending=%0d want 1", ref_pending);
        end
    endtask

    task automatic test_pullin();
        int first, second, exp1, exp2;
        logic prev;
        first = -1; second = -1; prev = 1'b0;
        exp1 = PULLIN ? 9 : 17;
        exp2 = PULLIN ? 19 : 33;
        host_req = 1'b0; mc_ready = 1'b1; init_done = 1'b1;
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        for (int k = 1; k <= 60 && second < 0; k++) begin
            cyc();
            if (mc_cmd_valid === 1'b1 && !prev) begin
                if (first < 0) first = k;
                else second = k;
            end
            prev = mc_cmd_valid;
        end
        tests++;
        if (first != exp1) begin
            fails++; $display("[TB] FAIL first_refresh_cycle: got %0d want %0d", first, exp1);
        end
        tests++;
        if (second != exp2) begin
            fails++; $display("[TB] FAIL second_refresh_cycle: got %0d want %0d", second, exp2);
        end
        mc_ready = 1'b0;
    endtask

    task automatic test_random();
        spurious = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cyc();
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("[TB] FAIL random_cycle_%0d: got %b want %b", i, dut_vec, model_vec());
            end
            if (i == 350) nrst = 1'b0;
            else nrst = 1'b1;
            mc_ready  = (((i / 80) % 3) == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
            init_done = ($urandom_range(0, 19) != 0);
            if (!host_req) begin
                host_req = ($urandom_range(0, 3) == 0);
                host_we  = $urandom_range(0, 1);
            end else if (host_grant || $urandom_range(0, 15) == 0) begin
                host_req = $urandom_range(0, 1);
            end
        end
        spurious = 1'b0;
        nrst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_refresh_tick();
        test_host_write();
        test_saturation();
        test_tick_accept();
        test_reset_mid();
        test_pullin();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
